// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system ID and timestamp words and
// compares them against build-time constants, flagging mismatches or a hung slave.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1361550840,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WT_ID,
    S_RD_TS,
    S_WT_TS,
    S_DONE
  } state_t;

  localparam logic [1:0]  LAT         = 2'(READ_LATENCY);
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_stall_cnt;
  logic [1:0]  r_lat_cnt;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_id_valid;
  logic        r_ts_valid;
  logic        r_timeout;

  logic w_rd_phase;
  logic w_accept;
  logic w_stall_hit;
  logic w_lat_last;
  logic w_clear;
  logic w_cap_id;
  logic w_cap_ts;
  logic w_set_timeout;

  assign w_rd_phase  = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign w_accept    = w_rd_phase && !avm_waitrequest;
  // The counter holds N-1 during the Nth stalled cycle, so this edge is the Nth.
  assign w_stall_hit = w_rd_phase && avm_waitrequest && (r_stall_cnt == STALL_LIMIT);
  assign w_lat_last  = (r_lat_cnt == LAT);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_next_state  = r_state;
    w_clear       = 1'b0;
    w_cap_id      = 1'b0;
    w_cap_ts      = 1'b0;
    w_set_timeout = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state = S_RD_ID;
          w_clear      = 1'b1;
        end
      end
      S_RD_ID: begin
        if (w_accept) begin
          if (LAT == 2'd0) begin
            w_cap_id     = 1'b1;
            w_next_state = S_RD_TS;
          end else begin
            w_next_state = S_WT_ID;
          end
        end else if (w_stall_hit) begin
          w_set_timeout = 1'b1;
          w_next_state  = S_DONE;
        end
      end
      S_WT_ID: begin
        if (w_lat_last) begin
          w_cap_id     = 1'b1;
          w_next_state = S_RD_TS;
        end
      end
      S_RD_TS: begin
        if (w_accept) begin
          if (LAT == 2'd0) begin
            w_cap_ts     = 1'b1;
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_WT_TS;
          end
        end else if (w_stall_hit) begin
          w_set_timeout = 1'b1;
          w_next_state  = S_DONE;
        end
      end
      S_WT_TS: begin
        if (w_lat_last) begin
          w_cap_ts     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_lat_cnt   <= '0;
    end else begin
      if (w_rd_phase && avm_waitrequest) r_stall_cnt <= r_stall_cnt + 16'd1;
      else                               r_stall_cnt <= '0;

      if (w_accept)                                        r_lat_cnt <= 2'd1;
      else if ((r_state == S_WT_ID) || (r_state == S_WT_TS)) r_lat_cnt <= r_lat_cnt + 2'd1;
      else                                                 r_lat_cnt <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_id_value <= '0;
      r_ts_value <= '0;
      r_id_valid <= 1'b0;
      r_ts_valid <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_clear) begin
        r_id_value <= '0;
        r_ts_value <= '0;
        r_id_valid <= 1'b0;
        r_ts_valid <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_cap_id) begin
        r_id_value <= avm_readdata;
        r_id_valid <= 1'b1;
      end
      if (w_cap_ts) begin
        r_ts_value <= avm_readdata;
        r_ts_valid <= 1'b1;
      end
      if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  // Flags compare the registered captures; a word never captured cannot mismatch.
  assign avm_read    = w_rd_phase;
  assign avm_address = (r_state == S_RD_TS);
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign id_mismatch = done && r_id_valid && (r_id_value != EXPECTED_ID);
  assign ts_mismatch = done && r_ts_valid && (r_ts_value != EXPECTED_TIMESTAMP);
  assign timeout     = r_timeout;
  assign pass        = done && !id_mismatch && !ts_mismatch && !r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule
